touch_pair_ctrl: RTL and testbench

- Controller for the dual capacitive touch pads on the side module.
- Synchronizes and debounces both raw pad inputs, then sequences a two-hand press gesture with a state machine:
  - both pads touched within a pairing window, then
  - both held for a hold time, then
  - a one-cycle activation pulse.
- Issues a timeout pulse on a one-handed touch and rearms only after full release.
- Replaces the plain AND of the two per-pad outputs at the side-module top level.

---
 rtl/touch_pkg.sv | 20 ++
 rtl/touch_debounce.sv | 57 +++++
 rtl/touch_pair_ctrl.sv | 130 +++++++++++++
 tb/tb_touch_pair_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// Shared types and default timing for the dual-pad touch gesture controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package touch_pkg;

  // Gesture FSM states; the encodings appear on the top-level state port.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PAIR = 3'd1,
    HOLD      = 3'd2,
    FIRED     = 3'd3,
    RELEASE   = 3'd4
  } touch_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_PAIR_WINDOW     = 1000;
  localparam int DEF_HOLD_CYCLES     = 5000;
  localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/touch_debounce.sv
// Synchronizes and debounces one raw asynchronous touch pad input.
// Latency: a clean raw edge reaches level exactly 2+DEBOUNCE_CYCLES cycles later.
// Backpressure: none; level is a free-running registered output.
//
// Ports: clk, rst (sync, active-high), raw (async pad), level (debounced).
module touch_debounce
  import touch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Count consecutive cycles the synced input disagrees with the level;
    // any agreement restarts the count, so short glitches never flip it.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/touch_pair_ctrl.sv
// Two-hand touch gesture controller: debounce both pads, pair, hold, then fire.
// Latency: press_pulse rises HOLD_CYCLES cycles after HOLD entry; outputs registered.
// Backpressure: none; pulses are single-cycle and fire-and-forget.
//
// Ports: clk, rst (sync, active-high), touch1/touch2 (raw async pads),
// enable (gesture enable), pressed1/pressed2 (debounced levels),
// touched (high in FIRED), press_pulse, timeout_pulse, state (FSM encoding).
module touch_pair_ctrl
  import touch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PAIR_WINDOW     = DEF_PAIR_WINDOW,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       touch1,
  input  logic       touch2,
  input  logic       enable,
  output logic       pressed1,
  output logic       pressed2,
  output logic       touched,
  output logic       press_pulse,
  output logic       timeout_pulse,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] PAIR_LAST = CNT_W'(PAIR_WINDOW - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  touch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             touched_q, touched_d;
  logic             press_pulse_q, press_pulse_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic             p1, p2, both, any;

  touch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .clk   (clk),
    .rst   (rst),
    .raw   (touch1),
    .level (p1)
  );

  touch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
    .clk   (clk),
    .rst   (rst),
    .raw   (touch2),
    .level (p2)
  );

  assign both = p1 & p2;
  assign any  = p1 | p2;

  always_comb begin
    state_d         = state_q;
    press_pulse_d   = 1'b0;
    timeout_pulse_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (both)     state_d = HOLD;
          else if (any) state_d = WAIT_PAIR;
        end
        WAIT_PAIR: begin
          // Pairing wins over the timeout if both land on the same cycle.
          if (both)      state_d = HOLD;
          else if (!any) state_d = IDLE;
          else if (cnt_q == PAIR_LAST) begin
            state_d         = RELEASE;
            timeout_pulse_d = 1'b1;
          end
        end
        HOLD: begin
          if (!both) state_d = RELEASE;
          else if (cnt_q == HOLD_LAST) begin
            state_d       = FIRED;
            press_pulse_d = 1'b1;
          end
        end
        FIRED: begin
          if (!both) state_d = RELEASE;
        end
        RELEASE: begin
          // Only a full release rearms; a re-press here is ignored.
          if (!any) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Shared gesture counter measures time spent in the current state.
    if (!enable || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    touched_d = (state_d == FIRED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      touched_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      touched_q       <= touched_d;
      press_pulse_q   <= press_pulse_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign pressed1      = p1;
  assign pressed2      = p2;
  assign touched       = touched_q;
  assign press_pulse   = press_pulse_q;
  assign timeout_pulse = timeout_pulse_q;
  assign state         = state_q;

endmodule

// File: tb/tb_touch_pair_ctrl.sv
// Bench for touch_pair_ctrl: directed gesture scenarios plus a random soak,
// each compared against a behavioural gesture model kept in this file.
module tb_touch_pair_ctrl;

  localparam int D  = 4;
  localparam int PW = 20;
  localparam int HC = 10;

  localparam int S_IDLE = 0, S_WAIT = 1, S_HOLD = 2, S_FIRED = 3, S_REL = 4;

  logic       clk = 1'b0;
  logic       rst, touch1, touch2, enable;
  logic       pressed1, pressed2, touched, press_pulse, timeout_pulse;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  touch_pair_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .PAIR_WINDOW    (PW),
    .HOLD_CYCLES    (HC),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .touch1       (touch1),
    .touch2       (touch2),
    .enable       (enable),
    .pressed1     (pressed1),
    .pressed2     (pressed2),
    .touched      (touched),
    .press_pulse  (press_pulse),
    .timeout_pulse(timeout_pulse),
    .state        (state)
  );

  // ---------------- behavioural model ----------------
  // Pads: raw samples captured per edge; the level flips once the D samples
  // that have passed the 2-flop delay all disagree with it.
  bit h1[$];
  bit h2[$];
  bit m_p1, m_p2, m_touched, m_pp, m_tp;
  int m_st, m_entry, m_cyc;

  function automatic bit window_flips(input bit h[$], input bit lvl);
    if (h.size() < D + 1) return 1'b0;
    for (int i = 0; i < D; i++) if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit both, none, np1, np2;
    int ns, elapsed;
    m_cyc++;
    if (rst) begin
      h1.delete(); h2.delete();
      m_p1 = 0; m_p2 = 0; m_touched = 0; m_pp = 0; m_tp = 0;
      m_st = S_IDLE; m_entry = m_cyc;
      return;
    end
    both    = m_p1 && m_p2;
    none    = !m_p1 && !m_p2;
    elapsed = m_cyc - m_entry - 1;   // full cycles already spent in m_st
    ns = m_st; m_pp = 0; m_tp = 0;
    if (!enable) ns = S_IDLE;
    else case (m_st)
      S_IDLE:  if (both) ns = S_HOLD; else if (!none) ns = S_WAIT;
      S_WAIT:  if (both) ns = S_HOLD; else if (none) ns = S_IDLE;
               else if (elapsed == PW - 1) begin ns = S_REL; m_tp = 1; end
      S_HOLD:  if (!both) ns = S_REL;
               else if (elapsed == HC - 1) begin ns = S_FIRED; m_pp = 1; end
      S_FIRED: if (!both) ns = S_REL;
      default: if (none) ns = S_IDLE;
    endcase
    if (ns != m_st || !enable) m_entry = m_cyc;
    m_st = ns;
    m_touched = (ns == S_FIRED);
    np1 = window_flips(h1, m_p1) ? !m_p1 : m_p1;
    np2 = window_flips(h2, m_p2) ? !m_p2 : m_p2;
    h1.push_back(touch1); if (h1.size() > D + 1) h1.pop_front();
    h2.push_back(touch2); if (h2.size() > D + 1) h2.pop_front();
    m_p1 = np1; m_p2 = np2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [7:0] dut_vec();
    return {pressed1, pressed2, touched, press_pulse, timeout_pulse, state};
  endfunction

  function automatic logic [7:0] mdl_vec();
    return {m_p1, m_p2, m_touched, m_pp, m_tp, 3'(m_st)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; touch1 = 1; touch2 = 1; enable = 1;
    repeat (3) tick();
    checks++;
    if (dut_vec() !== 8'h00) begin
      errors++; $display("FAIL reset_state: got %h want 00", dut_vec());
    end
    rst = 0; touch1 = 0; touch2 = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL reset_quiet k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic settle(input string tag);
    touch1 = 0; touch2 = 0; enable = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL %s_settle k=%0d: got %h want %h", tag, k, dut_vec(), mdl_vec());
      end
      if (m_st == S_IDLE && !m_p1 && !m_p2) break;
    end
    checks++;
    if (state !== 3'd0 || pressed1 !== 1'b0 || pressed2 !== 1'b0) begin
      errors++; $display("FAIL %s_idle: got state=%0d p=%b%b want 0 00", tag, state, pressed1, pressed2);
    end
  endtask

  task automatic test_pair_press();
    touch1 = 1; touch2 = 1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL pair_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
      checks++;
      if ({pressed1, pressed2} !== ((k >= 6) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL pair_pressed k=%0d: got %b%b", k, pressed1, pressed2);
      end
      if (k == 7) begin
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL pair_hold: got %0d want 2", state); end
      end
      checks++;
      if (press_pulse !== (k == 17) || touched !== (k >= 17)) begin
        errors++; $display("FAIL pair_fire k=%0d: got pulse=%b touched=%b", k, press_pulse, touched);
      end
    end
    settle("pair");
  endtask

  task automatic test_glitch();
    touch1 = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 3) touch1 = 0;
      checks++;
      if (dut_vec() !== mdl_vec() || pressed1 !== 1'b0 || state !== 3'd0) begin
        errors++; $display("FAIL glitch k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_timeout();
    touch1 = 1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL timeout_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
      checks++;
      if (timeout_pulse !== (k == 27) || press_pulse !== 1'b0) begin
        errors++; $display("FAIL timeout_pulse k=%0d: got to=%b pp=%b", k, timeout_pulse, press_pulse);
      end
      if (k == 7 || k == 26 || k == 28 || k == 32) begin
        checks++;
        if (state !== ((k >= 27) ? 3'd4 : 3'd1)) begin
          errors++; $display("FAIL timeout_state k=%0d: got %0d", k, state);
        end
      end
    end
    settle("timeout");
  endtask

  task automatic test_late_pair();
    touch1 = 1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 10) touch2 = 1;
      if (k == 20) touch2 = 0;
      checks++;
      if (dut_vec() !== mdl_vec() || timeout_pulse !== 1'b0 || press_pulse !== 1'b0) begin
        errors++; $display("FAIL late_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
      if (k == 16 || k == 17 || k == 26 || k == 27) begin
        checks++;
        if (state !== ((k == 16) ? 3'd1 : (k == 27) ? 3'd4 : 3'd2)) begin
          errors++; $display("FAIL late_state k=%0d: got %0d", k, state);
        end
      end
    end
    settle("late");
  endtask

  task automatic test_enable();
    int pulses = 0;
    touch1 = 1; touch2 = 1;
    repeat (10) tick();
    enable = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (state !== 3'd0 || press_pulse !== 1'b0 || {pressed1, pressed2} !== 2'b11 ||
          dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL enable_off k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
    end
    enable = 1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      pulses += press_pulse;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL enable_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (pulses !== 1 || state !== 3'd3) begin
      errors++; $display("FAIL enable_refire: got pulses=%0d state=%0d want 1 3", pulses, state);
    end
    settle("enable");
  endtask

  task automatic test_reset_fired();
    touch1 = 1; touch2 = 1;
    repeat (20) tick();
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL rstf_fired: got %0d want 3", state); end
    rst = 1;
    tick();
    checks++;
    if (dut_vec() !== 8'h00) begin errors++; $display("FAIL rstf_clear: got %h want 00", dut_vec()); end
    rst = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || state !== ((k >= 7) ? 3'd2 : 3'd0)) begin
        errors++; $display("FAIL rstf_rearm k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
    end
    settle("rstf");
  endtask

  task automatic test_random();
    int rate;
    for (int k = 0; k < 3000; k++) begin
      rate = ((k / 250) % 2 == 0) ? 10 : 60;
      if ($urandom_range(0, rate - 1) == 0) touch1 = ~touch1;
      if ($urandom_range(0, rate - 1) == 0) touch2 = ~touch2;
      if (!enable) enable = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 299) == 0) enable = 0;
      rst = ($urandom_range(0, 999) == 0);
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || (press_pulse && timeout_pulse)) begin
        errors++; $display("FAIL random k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
    end
    rst = 0;
    settle("random");
  endtask

  initial begin
    rst = 1; touch1 = 0; touch2 = 0; enable = 1;
    m_cyc = 0; m_entry = 0; m_st = S_IDLE;
    m_p1 = 0; m_p2 = 0; m_touched = 0; m_pp = 0; m_tp = 0;
    @(negedge clk);
    test_reset();
    test_pair_press();
    test_glitch();
    test_timeout();
    test_late_pair();
    test_enable();
    test_reset_fired();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
